// File: rtl/cipher_pkg.sv
// Shared types and helpers for the iterative XOR/rotate cipher engine.
// Rotations work on values up to CIPHER_MAXW bits; callers pass the live width.
package cipher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int CIPHER_MAXW = 64;
  localparam int CIPHER_IW   = $clog2(CIPHER_MAXW);

  // Rotate the low w bits of x left by n (mod w); bits above w are returned as zero.
  function automatic logic [CIPHER_MAXW-1:0] rotl(input logic [CIPHER_MAXW-1:0] x,
                                                  input int n, input int w);
    logic [CIPHER_MAXW-1:0] r;
    int s;
    r = '0;
    s = n % w;
    for (int i = 0; i < CIPHER_MAXW; i++) begin
      if (i < w) r[CIPHER_IW'((i + s) % w)] = x[CIPHER_IW'(i)];
    end
    return r;
  endfunction

  function automatic logic [CIPHER_MAXW-1:0] rotr(input logic [CIPHER_MAXW-1:0] x,
                                                  input int n, input int w);
    return rotl(x, w - (n % w), w);
  endfunction

endpackage

// File: rtl/xor_round_cipher_if.sv
// Operand/result handshake bundle for xor_round_cipher.
// master = source/sink side, slave = the cipher engine.
interface xor_round_cipher_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] in_key;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_key, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cipher_round.sv
// One combinational cipher round, shared by every RUN cycle of the engine.
module cipher_round
  import cipher_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_k,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_d
);
  always_comb begin
    o_d = '0;
    if (i_mode == MODE_DEC) o_d = WIDTH'(rotr(CIPHER_MAXW'(i_d), 1, WIDTH)) ^ i_k;
    else                    o_d = WIDTH'(rotl(CIPHER_MAXW'(i_d ^ i_k), 1, WIDTH));
  end
endmodule

// File: rtl/xor_round_cipher.sv
// Iterative multi-round XOR/rotate cipher, one round per clock, valid/ready on both sides.
// Define CIPHER_DONE_COUNT_EN to add the 16-bit done_count port (delivered blocks).
module xor_round_cipher
  import cipher_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ROUNDS = 4
) (
  input logic               clock,
  input logic               reset,
  xor_round_cipher_if.slave bus
`ifdef CIPHER_DONE_COUNT_EN
  ,
  output logic [15:0]       done_count
`endif
);
  localparam int CNT_W = $clog2(ROUNDS + 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_key;
  logic               r_mode;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_round_d;
  logic [WIDTH-1:0]   w_key_load;
  logic [WIDTH-1:0]   w_key_next;
  logic               w_accept;
  logic               w_deliver;
  logic               w_last;

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_deliver = (r_state == DONE) && bus.out_ready;
  assign w_last    = (r_cnt == CNT_W'(ROUNDS - 1));

  // Decrypt walks the round keys backwards, so it starts from the last one.
  assign w_key_load = (bus.in_mode == MODE_DEC)
                    ? WIDTH'(rotl(CIPHER_MAXW'(bus.in_key), ROUNDS - 1, WIDTH))
                    : bus.in_key;
  assign w_key_next = (r_mode == MODE_DEC)
                    ? WIDTH'(rotr(CIPHER_MAXW'(r_key), 1, WIDTH))
                    : WIDTH'(rotl(CIPHER_MAXW'(r_key), 1, WIDTH));

  cipher_round #(.WIDTH(WIDTH)) u_round (
    .i_d    (r_data),
    .i_k    (r_key),
    .i_mode (r_mode),
    .o_d    (w_round_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_key   <= '0;
      r_mode  <= MODE_ENC;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= RUN;
          r_data  <= bus.in_data;
          r_key   <= w_key_load;
          r_mode  <= bus.in_mode;
          r_cnt   <= '0;
        end
        RUN: begin
          r_data <= w_round_d;
          r_key  <= w_key_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) r_state <= DONE;
        end
        DONE: if (w_deliver) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !reset;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_data;

`ifdef CIPHER_DONE_COUNT_EN
  logic [15:0] r_done_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          r_done_cnt <= '0;
    else if (w_deliver) r_done_cnt <= r_done_cnt + 16'd1;
  end

  assign done_count = r_done_cnt;
`endif
endmodule

// File: tb/tb_xor_round_cipher.sv
// Directed bench for xor_round_cipher across several WIDTH/ROUNDS builds.
// Honours CIPHER_DONE_COUNT_EN for the optional done_count port.
module tb_xor_round_cipher;
  import cipher_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  xor_round_cipher_if #(.WIDTH(8))  b1 ();
  xor_round_cipher_if #(.WIDTH(8))  b2 ();
  xor_round_cipher_if #(.WIDTH(8))  b4 ();
  xor_round_cipher_if #(.WIDTH(13)) b13 ();

`ifdef CIPHER_DONE_COUNT_EN
  logic [15:0] dc1, dc2, dc4, dc13;
  xor_round_cipher #(.WIDTH(8),  .ROUNDS(1))  dut1  (.clock(clock), .reset(reset), .bus(b1),  .done_count(dc1));
  xor_round_cipher #(.WIDTH(8),  .ROUNDS(2))  dut2  (.clock(clock), .reset(reset), .bus(b2),  .done_count(dc2));
  xor_round_cipher #(.WIDTH(8),  .ROUNDS(4))  dut4  (.clock(clock), .reset(reset), .bus(b4),  .done_count(dc4));
  xor_round_cipher #(.WIDTH(13), .ROUNDS(20)) dut13 (.clock(clock), .reset(reset), .bus(b13), .done_count(dc13));
`else
  xor_round_cipher #(.WIDTH(8),  .ROUNDS(1))  dut1  (.clock(clock), .reset(reset), .bus(b1));
  xor_round_cipher #(.WIDTH(8),  .ROUNDS(2))  dut2  (.clock(clock), .reset(reset), .bus(b2));
  xor_round_cipher #(.WIDTH(8),  .ROUNDS(4))  dut4  (.clock(clock), .reset(reset), .bus(b4));
  xor_round_cipher #(.WIDTH(13), .ROUNDS(20)) dut13 (.clock(clock), .reset(reset), .bus(b13));
`endif

  task automatic drive(input int sel, input logic v, input logic [12:0] d, input logic [12:0] k,
                       input logic m, input logic r);
    case (sel)
      1: begin b1.in_valid = v; b1.in_data = d[7:0]; b1.in_key = k[7:0]; b1.in_mode = m; b1.out_ready = r; end
      2: begin b2.in_valid = v; b2.in_data = d[7:0]; b2.in_key = k[7:0]; b2.in_mode = m; b2.out_ready = r; end
      4: begin b4.in_valid = v; b4.in_data = d[7:0]; b4.in_key = k[7:0]; b4.in_mode = m; b4.out_ready = r; end
      default: begin b13.in_valid = v; b13.in_data = d; b13.in_key = k; b13.in_mode = m; b13.out_ready = r; end
    endcase
  endtask

  task automatic sample(input int sel, output logic ov, output logic ir, output logic [12:0] od);
    case (sel)
      1: begin ov = b1.out_valid; ir = b1.in_ready; od = {5'd0, b1.out_data}; end
      2: begin ov = b2.out_valid; ir = b2.in_ready; od = {5'd0, b2.out_data}; end
      4: begin ov = b4.out_valid; ir = b4.in_ready; od = {5'd0, b4.out_data}; end
      default: begin ov = b13.out_valid; ir = b13.in_ready; od = b13.out_data; end
    endcase
  endtask

  // Offer one block, wait (bounded) for the result, then complete the output handshake.
  // lat = edges from acceptance to out_valid, or -1 on timeout.
  task automatic run_block(input int sel, input int rounds, input logic [12:0] d, input logic [12:0] k,
                           input logic m, output logic [12:0] res, output int lat);
    logic ov, ir;
    logic [12:0] od;
    res = '0;
    lat = -1;
    @(negedge clock);
    drive(sel, 1'b1, d, k, m, 1'b0);
    @(negedge clock);
    drive(sel, 1'b0, d, k, m, 1'b0);
    for (int n = 0; n <= rounds + 4; n++) begin
      sample(sel, ov, ir, od);
      if (ov) begin
        res = od;
        lat = n;
        break;
      end
      @(negedge clock);
    end
    if (lat >= 0) begin
      drive(sel, 1'b0, d, k, m, 1'b1);
      @(negedge clock);
      drive(sel, 1'b0, d, k, m, 1'b0);
    end
  endtask

  function automatic logic [12:0] rol13(input logic [12:0] x, input int n);
    logic [12:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[11:0], y[12]};
    return y;
  endfunction

  function automatic logic [12:0] model_enc13(input logic [12:0] d, input logic [12:0] k);
    logic [12:0] y;
    y = d;
    for (int i = 0; i < 20; i++) y = rol13(y ^ rol13(k, i % 13), 1);
    return y;
  endfunction

  task automatic test_reset;
    logic ov, ir;
    logic [12:0] od;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    sample(4, ov, ir, od);
    n_checks++; if (ir !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b want=0", ir); end
    n_checks++; if (ov !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", ov); end
    n_checks++; if (od !== 13'h000) begin n_bad++; $display("FAIL reset_out_data got=%h want=00", od); end
`ifdef CIPHER_DONE_COUNT_EN
    n_checks++; if (dc4 !== 16'd0) begin n_bad++; $display("FAIL reset_done_count got=%0d want=0", dc4); end
`endif
    reset = 1'b0;
    #1;
    sample(4, ov, ir, od);
    n_checks++; if (ir !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got=%b want=1", ir); end
  endtask

  task automatic test_single_round;
    logic [12:0] res, od;
    logic ov, ir;
    int lat;
    run_block(1, 1, 13'h46, 13'h93, MODE_ENC, res, lat);
    n_checks++; if (res !== 13'h0AB) begin n_bad++; $display("FAIL r1_enc got=%h want=ab", res); end
    n_checks++; if (lat != 1) begin n_bad++; $display("FAIL r1_latency got=%0d want=1", lat); end
    sample(1, ov, ir, od);
    n_checks++; if (ov !== 1'b0 || ir !== 1'b1) begin n_bad++; $display("FAIL r1_after_hs got=%b%b want=01", ov, ir); end
  endtask

  task automatic test_two_round;
    logic [12:0] res;
    int lat;
    run_block(2, 2, 13'h46, 13'h93, MODE_ENC, res, lat);
    n_checks++; if (res !== 13'h019) begin n_bad++; $display("FAIL r2_enc got=%h want=19", res); end
    n_checks++; if (lat != 2) begin n_bad++; $display("FAIL r2_latency got=%0d want=2", lat); end
    run_block(2, 2, 13'h19, 13'h93, MODE_DEC, res, lat);
    n_checks++; if (res !== 13'h046) begin n_bad++; $display("FAIL r2_dec got=%h want=46", res); end
  endtask

  task automatic test_early_ready;
    logic ov, ir;
    logic [12:0] od;
    @(negedge clock);
    drive(2, 1'b1, 13'h46, 13'h93, MODE_ENC, 1'b1);
    @(negedge clock);
    drive(2, 1'b0, 13'h46, 13'h93, MODE_ENC, 1'b1);
    @(negedge clock);
    sample(2, ov, ir, od);
    n_checks++; if (ov !== 1'b0) begin n_bad++; $display("FAIL early_mid_valid got=%b want=0", ov); end
    @(negedge clock);
    sample(2, ov, ir, od);
    n_checks++; if (ov !== 1'b1 || od !== 13'h019) begin n_bad++; $display("FAIL early_result got=%b/%h want=1/19", ov, od); end
    @(negedge clock);
    sample(2, ov, ir, od);
    n_checks++; if (ov !== 1'b0 || ir !== 1'b1) begin n_bad++; $display("FAIL early_hs got=%b%b want=01", ov, ir); end
    drive(2, 1'b0, 13'h0, 13'h0, MODE_ENC, 1'b0);
  endtask

  task automatic test_four_round;
    logic [12:0] res;
    int lat;
    run_block(4, 4, 13'h46, 13'h93, MODE_ENC, res, lat);
    n_checks++; if (res !== 13'h064) begin n_bad++; $display("FAIL r4_enc_a got=%h want=64", res); end
    n_checks++; if (lat != 4) begin n_bad++; $display("FAIL r4_latency got=%0d want=4", lat); end
    run_block(4, 4, 13'h64, 13'h93, MODE_DEC, res, lat);
    n_checks++; if (res !== 13'h046) begin n_bad++; $display("FAIL r4_dec_a got=%h want=46", res); end
    run_block(4, 4, 13'h01, 13'h00, MODE_ENC, res, lat);
    n_checks++; if (res !== 13'h010) begin n_bad++; $display("FAIL r4_enc_b got=%h want=10", res); end
    run_block(4, 4, 13'h10, 13'h00, MODE_DEC, res, lat);
    n_checks++; if (res !== 13'h001) begin n_bad++; $display("FAIL r4_dec_b got=%h want=01", res); end
  endtask

  task automatic test_back_pressure;
    logic ov, ir;
    logic [12:0] od;
    bit seen, stable;
    int lat;
    @(negedge clock);
    drive(4, 1'b1, 13'h46, 13'h93, MODE_ENC, 1'b0);
    @(negedge clock);
    drive(4, 1'b1, 13'h01, 13'h00, MODE_ENC, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      sample(4, ov, ir, od);
      if (ov) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    n_checks++; if (seen !== 1'b1) begin n_bad++; $display("FAIL bp_first_valid got=%b want=1", seen); end
    if (seen) begin
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
        sample(4, ov, ir, od);
        if (ov !== 1'b1 || ir !== 1'b0 || od !== 13'h064) stable = 1'b0;
        @(negedge clock);
      end
      n_checks++; if (stable !== 1'b1) begin n_bad++; $display("FAIL bp_hold got=%b%b/%h want=10/64", ov, ir, od); end
      drive(4, 1'b1, 13'h01, 13'h00, MODE_ENC, 1'b1);
      @(negedge clock);
      sample(4, ov, ir, od);
      n_checks++; if (ov !== 1'b0 || ir !== 1'b1) begin n_bad++; $display("FAIL bp_after_hs got=%b%b want=01", ov, ir); end
      drive(4, 1'b1, 13'h01, 13'h00, MODE_ENC, 1'b0);
      @(negedge clock);
      sample(4, ov, ir, od);
      n_checks++; if (ir !== 1'b0) begin n_bad++; $display("FAIL bp_b_accept got=%b want=0", ir); end
      drive(4, 1'b0, 13'h0, 13'h0, MODE_ENC, 1'b0);
      lat = -1;
      for (int n = 0; n < 10; n++) begin
        sample(4, ov, ir, od);
        if (ov) begin lat = n; break; end
        @(negedge clock);
      end
      n_checks++; if (lat != 4 || od !== 13'h010) begin n_bad++; $display("FAIL bp_b_result got=%0d/%h want=4/10", lat, od); end
      drive(4, 1'b0, 13'h0, 13'h0, MODE_ENC, 1'b1);
      @(negedge clock);
      drive(4, 1'b0, 13'h0, 13'h0, MODE_ENC, 1'b0);
    end
  endtask

  task automatic test_reset_mid_run;
    logic ov, ir;
    logic [12:0] od, res;
    bit any_valid;
    int lat;
    @(negedge clock);
    drive(4, 1'b1, 13'h46, 13'h93, MODE_ENC, 1'b1);
    @(negedge clock);
    drive(4, 1'b0, 13'h46, 13'h93, MODE_ENC, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    sample(4, ov, ir, od);
    n_checks++; if (ir !== 1'b0 || ov !== 1'b0 || od !== 13'h0) begin n_bad++; $display("FAIL rst_run_during got=%b%b/%h want=00/00", ir, ov, od); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    sample(4, ov, ir, od);
    n_checks++; if (ir !== 1'b1 || ov !== 1'b0 || od !== 13'h0) begin n_bad++; $display("FAIL rst_run_after got=%b%b/%h want=10/00", ir, ov, od); end
    any_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      sample(4, ov, ir, od);
      if (ov) any_valid = 1'b1;
    end
    n_checks++; if (any_valid !== 1'b0) begin n_bad++; $display("FAIL rst_run_no_output got=%b want=0", any_valid); end
    drive(4, 1'b0, 13'h0, 13'h0, MODE_ENC, 1'b0);
    run_block(4, 4, 13'h46, 13'h93, MODE_ENC, res, lat);
    n_checks++; if (res !== 13'h064 || lat != 4) begin n_bad++; $display("FAIL rst_run_next got=%h/%0d want=64/4", res, lat); end
  endtask

  task automatic test_done_count;
`ifdef CIPHER_DONE_COUNT_EN
    logic [12:0] res;
    int lat;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) run_block(1, 1, 13'h46, 13'h93, MODE_ENC, res, lat);
    n_checks++; if (dc1 !== 16'd3) begin n_bad++; $display("FAIL done_count_3 got=%0d want=3", dc1); end
    reset = 1'b1;
    #1;
    n_checks++; if (dc1 !== 16'd0) begin n_bad++; $display("FAIL done_count_reset got=%0d want=0", dc1); end
    @(negedge clock);
    reset = 1'b0;
`endif
  endtask

  task automatic test_roundtrip;
    logic [12:0] x, k, c, p;
    int lat;
    for (int i = 0; i < 500; i++) begin
      x = 13'($urandom_range(0, 8191));
      k = 13'($urandom_range(0, 8191));
      run_block(13, 20, x, k, MODE_ENC, c, lat);
      n_checks++;
      if (c !== model_enc13(x, k) || lat != 20) begin
        n_bad++; $display("FAIL rt_enc x=%h k=%h got=%h/%0d want=%h/20", x, k, c, lat, model_enc13(x, k));
      end
      run_block(13, 20, c, k, MODE_DEC, p, lat);
      n_checks++;
      if (p !== x) begin n_bad++; $display("FAIL rt_dec k=%h got=%h want=%h", k, p, x); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d bad=%0d", n_checks, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 1'b0, 13'h0, 13'h0, MODE_ENC, 1'b0);
    drive(2, 1'b0, 13'h0, 13'h0, MODE_ENC, 1'b0);
    drive(4, 1'b0, 13'h0, 13'h0, MODE_ENC, 1'b0);
    drive(13, 1'b0, 13'h0, 13'h0, MODE_ENC, 1'b0);
    test_reset();
    test_single_round();
    test_two_round();
    test_early_ready();
    test_four_round();
    test_back_pressure();
    test_reset_mid_run();
    test_done_count();
    test_roundtrip();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
